pipe_stage_skid: RTL and testbench

Parametrised inter-stage pipeline register for the RISC-V pipeline, successor to the fixed-field stage latches between EX/MEM/WB. It carries a control field and a data field, and adds a valid/ready handshake with a two-entry skid buffer, synchronous flush, and bubble insertion. It also keeps a saturating back-pressure counter. Each instance sits between two pipeline stages; the hazard unit drives `flush`.

---
 rtl/pipe_pkg.sv | 14 +
 rtl/sat_counter.sv | 22 ++
 rtl/pipe_stage_skid.sv | 100 ++++++++++
 tb/tb_pipe_stage_skid.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and bubble constants for pipeline stage registers
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_e;

    // Control layout: bit0 rf_we, bits[2:1] wd_sel; a bubble must never write the register file
    localparam logic [7:0] CTRL_BUBBLE_MEM = 8'b0000_0100;
    localparam logic [7:0] CTRL_BUBBLE_WB  = 8'b0000_0100;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - enabled up-counter that sticks at all-ones
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX_VAL = {W{1'b1}};
    localparam logic [W-1:0] ONE_VAL = {{(W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != MAX_VAL)) begin
            count <= count + ONE_VAL;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - inter-stage register with two-entry skid, flush and bubble insertion
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                CTRL_W      = 8,
    parameter int                DATA_W      = 128,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = {CTRL_W{1'b0}},
    parameter int                CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [CTRL_W-1:0] up_ctrl,
    input  logic [DATA_W-1:0] up_data,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [CTRL_W-1:0] dn_ctrl,
    output logic [DATA_W-1:0] dn_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    stage_state_e      state;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              accept;
    logic              take;

    assign accept = up_valid & up_ready;
    assign take   = dn_valid & dn_ready;

    // dn_valid and up_ready are kept as flops alongside state so neither has a path from dn_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            dn_valid  <= 1'b0;
            up_ready  <= 1'b1;
            dn_ctrl   <= CTRL_BUBBLE;
            dn_data   <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else if (flush) begin
            state    <= EMPTY;
            dn_valid <= 1'b0;
            up_ready <= 1'b1;
            dn_ctrl  <= CTRL_BUBBLE;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state    <= ONE;
                        dn_valid <= 1'b1;
                        dn_ctrl  <= up_ctrl;
                        dn_data  <= up_data;
                    end
                end
                ONE: begin
                    if (accept && take) begin
                        dn_ctrl <= up_ctrl;
                        dn_data <= up_data;
                    end else if (accept) begin
                        state     <= FULL;
                        up_ready  <= 1'b0;
                        skid_ctrl <= up_ctrl;
                        skid_data <= up_data;
                    end else if (take) begin
                        state    <= EMPTY;
                        dn_valid <= 1'b0;
                        dn_ctrl  <= CTRL_BUBBLE;
                    end
                end
                FULL: begin
                    if (take) begin
                        state    <= ONE;
                        up_ready <= 1'b1;
                        dn_ctrl  <= skid_ctrl;
                        dn_data  <= skid_data;
                    end
                end
                default: begin
                    state    <= EMPTY;
                    dn_valid <= 1'b0;
                    up_ready <= 1'b1;
                    dn_ctrl  <= CTRL_BUBBLE;
                end
            endcase
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (dn_valid & ~dn_ready),
        .count(stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - directed scoreboard bench for pipe_stage_skid
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    localparam int CTRL_W = 8;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;
    localparam logic [CTRL_W-1:0] BUB = CTRL_BUBBLE_MEM;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              up_valid;
    logic              up_ready;
    logic [CTRL_W-1:0] up_ctrl;
    logic [DATA_W-1:0] up_data;
    logic              dn_valid;
    logic              dn_ready;
    logic [CTRL_W-1:0] dn_ctrl;
    logic [DATA_W-1:0] dn_data;
    logic [CNT_W-1:0]  stall_cnt;

    pipe_stage_skid #(
        .CTRL_W     (CTRL_W),
        .DATA_W     (DATA_W),
        .CTRL_BUBBLE(BUB),
        .CNT_W      (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .up_valid (up_valid),
        .up_ready (up_ready),
        .up_ctrl  (up_ctrl),
        .up_data  (up_data),
        .dn_valid (dn_valid),
        .dn_ready (dn_ready),
        .dn_ctrl  (dn_ctrl),
        .dn_data  (dn_data),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    logic [CTRL_W+DATA_W-1:0] sb[$];
    int total  = 0;
    int passed = 0;
    int taken  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Called with inputs settled, just before the next rising edge is awaited
    task automatic cycle();
        logic acc, tk;
        logic [CTRL_W+DATA_W-1:0] e;
        acc = up_valid && up_ready;
        tk  = dn_valid && dn_ready;
        if (tk) begin
            taken++;
            if (sb.size() == 0) begin
                chk("unexpected_output", 64'(dn_data), 64'hDEAD);
            end else begin
                e = sb.pop_front();
                chk("out_ctrl", 64'(dn_ctrl), 64'(e[CTRL_W+DATA_W-1:DATA_W]));
                chk("out_data", 64'(dn_data), 64'(e[DATA_W-1:0]));
            end
        end
        if (flush) sb.delete();
        else if (acc) sb.push_back({up_ctrl, up_data});
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
        up_valid = 1'b1;
        up_ctrl  = c;
        up_data  = d;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; up_valid = 1'b0; up_ctrl = '0; up_data = '0; dn_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dn_valid", 64'(dn_valid), 64'd0);
        chk("rst_up_ready", 64'(up_ready), 64'd1);
        chk("rst_dn_ctrl", 64'(dn_ctrl), 64'(BUB));
        chk("rst_dn_data", 64'(dn_data), 64'd0);
        chk("rst_stall", 64'(stall_cnt), 64'd0);
        rst_n = 1'b1;

        // Streaming: 10 entries out in 11 cycles
        dn_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            offer(8'h81, DATA_W'(i + 1));
            cycle();
            if (i == 0) begin
                chk("lat_dn_valid", 64'(dn_valid), 64'd1);
                chk("lat_dn_data", 64'(dn_data), 64'd1);
            end
        end
        up_valid = 1'b0;
        cycle();
        chk("stream_count", 64'(taken), 64'd10);
        chk("stream_empty", 64'(dn_valid), 64'd0);
        chk("stream_bubble", 64'(dn_ctrl), 64'(BUB));

        // Back-pressure: A main, B skid, C refused
        dn_ready = 1'b0;
        offer(8'hA1, 32'hA); cycle();
        offer(8'hB2, 32'hB); cycle();
        chk("bp_up_ready", 64'(up_ready), 64'd0);
        chk("bp_main", 64'(dn_data), 64'hA);
        offer(8'hC3, 32'hC); cycle();
        cycle();
        chk("bp_held_stall", 64'(stall_cnt), 64'd3);
        chk("bp_still_full", 64'(up_ready), 64'd0);
        dn_ready = 1'b1;
        cycle();
        cycle();
        up_valid = 1'b0;
        cycle();
        chk("bp_count", 64'(taken), 64'd13);
        chk("bp_stall_final", 64'(stall_cnt), 64'd3);
        chk("bp_drained", 64'(dn_valid), 64'd0);

        // Flush while FULL: skid entry must never emerge
        dn_ready = 1'b0;
        offer(8'hD4, 32'hD); cycle();
        offer(8'hE5, 32'hE); cycle();
        up_valid = 1'b0; flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("fl_dn_valid", 64'(dn_valid), 64'd0);
        chk("fl_dn_ctrl", 64'(dn_ctrl), 64'(BUB));
        chk("fl_up_ready", 64'(up_ready), 64'd1);
        dn_ready = 1'b1;
        repeat (3) cycle();
        chk("fl_no_skid", 64'(dn_valid), 64'd0);
        chk("fl_count", 64'(taken), 64'd13);

        // Flush with simultaneous offer drops it; next offer passes
        offer(8'hF6, 32'hF); flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("fl_drop", 64'(dn_valid), 64'd0);
        offer(8'h17, 32'h17); cycle();
        chk("fl_next_valid", 64'(dn_valid), 64'd1);
        chk("fl_next_data", 64'(dn_data), 64'h17);
        up_valid = 1'b0; cycle();
        chk("fl_next_count", 64'(taken), 64'd14);
        chk("stall_after_fl", 64'(stall_cnt), 64'd5);

        // Saturation of the 4-bit stall counter
        dn_ready = 1'b0;
        offer(8'h28, 32'h28); cycle();
        up_valid = 1'b0;
        repeat (20) cycle();
        chk("sat_15", 64'(stall_cnt), 64'd15);
        repeat (3) cycle();
        chk("sat_hold", 64'(stall_cnt), 64'd15);

        // Asynchronous reset while FULL, between edges
        offer(8'h39, 32'h39); cycle();
        up_valid = 1'b0;
        chk("ar_full", 64'(up_ready), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_dn_valid", 64'(dn_valid), 64'd0);
        chk("ar_up_ready", 64'(up_ready), 64'd1);
        chk("ar_dn_ctrl", 64'(dn_ctrl), 64'(BUB));
        chk("ar_dn_data", 64'(dn_data), 64'd0);
        chk("ar_stall", 64'(stall_cnt), 64'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        dn_ready = 1'b1;
        repeat (2) cycle();
        chk("ar_no_stale", 64'(dn_valid), 64'd0);
        offer(8'h4A, 32'h4A); cycle();
        chk("ar_first_valid", 64'(dn_valid), 64'd1);
        chk("ar_first_data", 64'(dn_data), 64'h4A);
        up_valid = 1'b0; cycle();
        chk("ar_count", 64'(taken), 64'd15);
        chk("sb_empty_end", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
